// File: rtl/reg_bank_onehot.sv
// 32 x WIDTH register bank: one-hot write select with fault counting, sequential clear engine.
// Reads take 1 cycle on both ports. Clear takes 32 cycles; WRITE_BYPASS_EN enables write-through.
// No backpressure: a write during busy is dropped silently, and clr_req during busy is ignored.
module reg_bank_onehot #(
    parameter int WIDTH = 32,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wen,
    input  logic [31:0]      wsel,
    input  logic [WIDTH-1:0] wdata,
    input  logic [4:0]       raddr_a,
    input  logic [4:0]       raddr_b,
    output logic [WIDTH-1:0] rdata_a,
    output logic [WIDTH-1:0] rdata_b,
    input  logic             clr_req,
    output logic             busy,
    output logic             sel_err,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [4:0]       ptr_q;
    logic [4:0]       ptr_d;
    logic [WIDTH-1:0] regs [32];
    logic             sel_onehot;
    logic             wr_ok;
    logic             wr_bad;
    logic             clr_we;

    // Exactly one bit set: nonzero, and clearing the lowest set bit leaves nothing.
    assign sel_onehot = (wsel != 32'd0) && ((wsel & (wsel - 32'd1)) == 32'd0);
    assign busy       = (state_q == CLEAR);
    assign wr_ok      = wen && !busy && sel_onehot;
    assign wr_bad     = wen && !busy && !sel_onehot;
    assign clr_we     = (state_q == CLEAR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d = CLEAR;
                    ptr_d   = 5'd0;
                end
            end
            CLEAR: begin
                ptr_d = ptr_q + 5'd1;
                if (ptr_q == 5'd31) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                ptr_d   = 5'd0;
            end
        endcase
    end

    // Writes and clear writes never coincide: writes are only accepted while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 32; i++) begin
                if (wr_ok && wsel[i]) begin
                    regs[i] <= wdata;
                end else if (clr_we && (ptr_q == 5'(i))) begin
                    regs[i] <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
`ifdef WRITE_BYPASS_EN
            rdata_a <= (wr_ok && wsel[raddr_a]) ? wdata : regs[raddr_a];
            rdata_b <= (wr_ok && wsel[raddr_b]) ? wdata : regs[raddr_b];
`else
            rdata_a <= regs[raddr_a];
            rdata_b <= regs[raddr_b];
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_err <= 1'b0;
            err_cnt <= '0;
        end else begin
            sel_err <= wr_bad;
            if (wr_bad && (err_cnt != {ERR_W{1'b1}})) begin
                err_cnt <= err_cnt + ERR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_reg_bank_onehot.sv
// Directed bench for reg_bank_onehot: reset, write/read, bad selects, clear engine, abort.
module tb_reg_bank_onehot;

    localparam int WIDTH = 32;
    localparam int ERR_W = 8;

    logic             clk;
    logic             rst_n;
    logic             wen;
    logic [31:0]      wsel;
    logic [WIDTH-1:0] wdata;
    logic [4:0]       raddr_a;
    logic [4:0]       raddr_b;
    logic [WIDTH-1:0] rdata_a;
    logic [WIDTH-1:0] rdata_b;
    logic             clr_req;
    logic             busy;
    logic             sel_err;
    logic [ERR_W-1:0] err_cnt;

    int n_cmp;
    int n_err;

    reg_bank_onehot #(.WIDTH(WIDTH), .ERR_W(ERR_W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wen     (wen),
        .wsel    (wsel),
        .wdata   (wdata),
        .raddr_a (raddr_a),
        .raddr_b (raddr_b),
        .rdata_a (rdata_a),
        .rdata_b (rdata_b),
        .clr_req (clr_req),
        .busy    (busy),
        .sel_err (sel_err),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input logic [31:0] d);
        wen   = 1'b1;
        wsel  = 32'd1 << idx;
        wdata = d;
        tick();
        wen  = 1'b0;
        wsel = 32'd0;
    endtask

    task automatic rd(input int a, input int b);
        raddr_a = 5'(a);
        raddr_b = 5'(b);
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        n_cmp++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin n_err++; $display("FAIL reset_rdata a=%h b=%h want 0", rdata_a, rdata_b); end
        n_cmp++; if (busy !== 1'b0 || sel_err !== 1'b0 || err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_ctl busy=%b sel_err=%b err_cnt=%0d want 0/0/0", busy, sel_err, err_cnt); end
        tick();
        rst_n = 1'b1;
        tick();
        // Dirty some state, then assert reset between clock edges.
        wr(3, 32'hAAAA_5555);
        wen = 1'b1; wsel = 32'h0000_0003; tick(); wen = 1'b0; wsel = 32'd0;
        rd(3, 3);
        n_cmp++; if (rdata_a !== 32'hAAAA_5555 || err_cnt !== 8'd1) begin n_err++; $display("FAIL reset_pre a=%h cnt=%0d want aaaa5555/1", rdata_a, err_cnt); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0 || busy !== 1'b0 || err_cnt !== 8'd0) begin n_err++; $display("FAIL reset_async a=%h b=%h busy=%b cnt=%0d want 0", rdata_a, rdata_b, busy, err_cnt); end
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            rd(i, 31 - i);
            n_cmp++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin n_err++; $display("FAIL reset_regs i=%0d a=%h b=%h want 0", i, rdata_a, rdata_b); end
        end
    endtask

    task automatic test_write_read();
        raddr_b = 5'd4;
        wr(5, 32'hDEAD_BEEF);
        raddr_a = 5'd5;
        tick();
        n_cmp++; if (rdata_a !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL wr_rd_a5 got=%h want deadbeef", rdata_a); end
        n_cmp++; if (rdata_b !== 32'd0) begin n_err++; $display("FAIL wr_rd_b4 got=%h want 0", rdata_b); end
        n_cmp++; if (sel_err !== 1'b0 || err_cnt !== 8'd0) begin n_err++; $display("FAIL wr_rd_err sel_err=%b cnt=%0d want 0/0", sel_err, err_cnt); end
    endtask

    task automatic test_bad_select();
        wen = 1'b1; wsel = 32'h0000_0003; wdata = 32'hFFFF_FFFF;
        tick();
        wen = 1'b0; wsel = 32'd0;
        n_cmp++; if (sel_err !== 1'b1 || err_cnt !== 8'd1) begin n_err++; $display("FAIL bad_two sel_err=%b cnt=%0d want 1/1", sel_err, err_cnt); end
        tick();
        n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL bad_pulse sel_err=%b want 0", sel_err); end
        rd(0, 1);
        n_cmp++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin n_err++; $display("FAIL bad_noreg r0=%h r1=%h want 0", rdata_a, rdata_b); end
        wen = 1'b1; wsel = 32'd0; wdata = 32'h1111_1111;
        tick();
        wen = 1'b0;
        n_cmp++; if (sel_err !== 1'b1 || err_cnt !== 8'd2) begin n_err++; $display("FAIL bad_zero sel_err=%b cnt=%0d want 1/2", sel_err, err_cnt); end
        wen = 1'b1; wsel = 32'h0000_00F0;
        for (int k = 0; k < 300; k++) tick();
        n_cmp++; if (err_cnt !== 8'd255 || sel_err !== 1'b1) begin n_err++; $display("FAIL bad_sat cnt=%0d sel_err=%b want 255/1", err_cnt, sel_err); end
        wen = 1'b0; wsel = 32'd0;
        tick();
        n_cmp++; if (err_cnt !== 8'd255 || sel_err !== 1'b0) begin n_err++; $display("FAIL bad_hold cnt=%0d sel_err=%b want 255/0", err_cnt, sel_err); end
        rd(5, 4);
        n_cmp++; if (rdata_a !== 32'hDEAD_BEEF || rdata_b !== 32'd0) begin n_err++; $display("FAIL bad_keep r5=%h r4=%h want deadbeef/0", rdata_a, rdata_b); end
    endtask

    task automatic test_clear();
        int cnt;
        bool_t_dummy();
        for (int i = 0; i < 32; i++) wr(i, 32'hA500_0000 + i);
        rd(19, 31);
        n_cmp++; if (rdata_a !== 32'hA500_0013 || rdata_b !== 32'hA500_001F) begin n_err++; $display("FAIL clr_load a=%h b=%h want a5000013/a500001f", rdata_a, rdata_b); end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = busy ? 1 : 0;
        while (busy && cnt < 100) begin
            wen = 1'b0; wsel = 32'd0;
            if (cnt == 5) begin wen = 1'b1; wsel = 32'h0000_0001; wdata = 32'h0000_ABCD; end
            if (cnt == 7) begin wen = 1'b1; wsel = 32'h0000_0003; end
            if (cnt == 10) clr_req = 1'b1;
            raddr_a = (cnt == 19) ? 5'd19 : 5'd0;
            tick();
            clr_req = 1'b0;
            if (cnt == 5 || cnt == 7) begin
                n_cmp++; if (sel_err !== 1'b0) begin n_err++; $display("FAIL clr_busy_wen cnt=%0d sel_err=%b want 0", cnt, sel_err); end
            end
            if (cnt == 19) begin
                n_cmp++; if (rdata_a !== 32'hA500_0013) begin n_err++; $display("FAIL clr_noby got=%h want a5000013", rdata_a); end
            end
            if (busy) cnt++;
        end
        wen = 1'b0; wsel = 32'd0;
        n_cmp++; if (cnt !== 32) begin n_err++; $display("FAIL clr_len busy_cycles=%0d want 32", cnt); end
        for (int i = 0; i < 32; i++) begin
            rd(i, i);
            n_cmp++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin n_err++; $display("FAIL clr_zero i=%0d a=%h b=%h want 0", i, rdata_a, rdata_b); end
        end
    endtask

    task automatic bool_t_dummy();
        wen = 1'b0; wsel = 32'd0; clr_req = 1'b0;
    endtask

    task automatic test_same_cycle();
        raddr_b = 5'd7;
        wr(7, 32'h1234_5678);
`ifdef WRITE_BYPASS_EN
        n_cmp++; if (rdata_b !== 32'h1234_5678) begin n_err++; $display("FAIL same_edge got=%h want 12345678", rdata_b); end
`else
        n_cmp++; if (rdata_b !== 32'd0) begin n_err++; $display("FAIL same_edge got=%h want 0", rdata_b); end
`endif
        tick();
        n_cmp++; if (rdata_b !== 32'h1234_5678) begin n_err++; $display("FAIL same_next got=%h want 12345678", rdata_b); end
    endtask

    task automatic test_back_to_back();
        wr(8, 32'h0808_0808);
        wr(9, 32'h0909_0909);
        rd(8, 8);
        n_cmp++; if (rdata_a !== 32'h0808_0808 || rdata_b !== 32'h0808_0808) begin n_err++; $display("FAIL b2b_same a=%h b=%h want 08080808", rdata_a, rdata_b); end
        rd(9, 7);
        n_cmp++; if (rdata_a !== 32'h0909_0909 || rdata_b !== 32'h1234_5678) begin n_err++; $display("FAIL b2b_diff a=%h b=%h want 09090909/12345678", rdata_a, rdata_b); end
    endtask

    task automatic test_wen_with_clr();
        int cnt;
        wen = 1'b1; wsel = 32'h0000_0400; wdata = 32'h0000_0055; clr_req = 1'b1;
        tick();
        wen = 1'b0; wsel = 32'd0; clr_req = 1'b0;
        rd(10, 10);
        n_cmp++; if (rdata_a !== 32'h0000_0055 || busy !== 1'b1) begin n_err++; $display("FAIL wclr_accept r10=%h busy=%b want 55/1", rdata_a, busy); end
        cnt = 0;
        while (busy && cnt < 100) begin tick(); cnt++; end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL wclr_timeout busy=%b want 0", busy); end
        rd(10, 9);
        n_cmp++; if (rdata_a !== 32'd0 || rdata_b !== 32'd0) begin n_err++; $display("FAIL wclr_zero r10=%h r9=%h want 0", rdata_a, rdata_b); end
    endtask

    task automatic test_abort();
        int cnt;
        wr(2, 32'h0202_0202);
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 1;
        while (cnt < 10) begin tick(); cnt++; end
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL abort_pre busy=%b want 1", busy); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_async busy=%b want 0", busy); end
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_idle busy=%b want 0", busy); end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = busy ? 1 : 0;
        while (busy && cnt < 100) begin
            tick();
            if (busy) cnt++;
        end
        n_cmp++; if (cnt !== 32) begin n_err++; $display("FAIL abort_fresh busy_cycles=%0d want 32", cnt); end
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b1; wen = 1'b0; wsel = 32'd0; wdata = 32'd0;
        raddr_a = 5'd0; raddr_b = 5'd0; clr_req = 1'b0;
        test_reset();
        test_write_read();
        test_bad_select();
        test_clear();
        test_same_cycle();
        test_back_to_back();
        test_wen_with_clr();
        test_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
